// File: rtl/pad_autoread_ctrl.sv
// Controller-port auto-read sequencer.
// Strobes OUT0, then clocks NUM_BITS serial bits from both ports with
// active-low /IN0 and /IN1 read pulses and presents two parallel words.
// While a sequence runs it owns the OUT0 and /IN pad drives; otherwise the
// CPU register path passes straight through to the pad cells.
module pad_autoread_ctrl #(
    parameter int NUM_BITS      = 8,
    parameter int STROBE_CYCLES = 2,
    parameter int READ_GAP      = 1
) (
    input  logic                ACLK1,
    input  logic                n_RES,
    input  logic                start,
    input  logic                abort,
    input  logic                cpu_out0,
    input  logic                cpu_n_r4016,
    input  logic                cpu_n_r4017,
    input  logic                cpu_w4016,
    input  logic                pad_d0,
    input  logic                pad_d1,
    output logic                out0_drv,
    output logic                n_in0_drv,
    output logic                n_in1_drv,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] pad0_data,
    output logic [NUM_BITS-1:0] pad1_data,
    output logic                collision
);

    // Bit counter must be able to hold NUM_BITS itself (value after the last GAP).
    localparam int BW   = $clog2(NUM_BITS + 1);
    // Phase counter times both the strobe-high window and the inter-read gap.
    localparam int PMAX = (STROBE_CYCLES > READ_GAP) ? STROBE_CYCLES : READ_GAP;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STROBE_HI = 3'd1,
        ST_STROBE_LO = 3'd2,
        ST_READ      = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]       phase_cnt_q, phase_cnt_d;
    logic [BW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [BW-1:0]       bit_cnt_inc;
    logic [NUM_BITS-1:0] shift0_q,    shift0_d;
    logic [NUM_BITS-1:0] shift1_q,    shift1_d;
    logic [NUM_BITS-1:0] res0_q,      res0_d;
    logic [NUM_BITS-1:0] res1_q,      res1_d;
    logic                collision_q, collision_d;

    logic [NUM_BITS-1:0] shift0_next;
    logic [NUM_BITS-1:0] shift1_next;

    logic start_ok;
    logic abort_now;
    logic strobe_last;
    logic gap_last;
    logic more_bits;
    logic cpu_touch;
    logic strobe_int;
    logic n_in_int;

    // A start is only honoured from IDLE, and a coincident abort vetoes it.
    assign start_ok    = (state_q == ST_IDLE) && start && !abort;
    // Abort cuts the sequence short everywhere except IDLE and DONE;
    // DONE is allowed to finish so the result is never half-loaded.
    assign abort_now   = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign strobe_last = (phase_cnt_q == PW'(STROBE_CYCLES - 1));
    assign gap_last    = (phase_cnt_q == PW'(READ_GAP - 1));
    assign bit_cnt_inc = bit_cnt_q + BW'(1);
    assign more_bits   = (bit_cnt_inc < BW'(NUM_BITS));
    assign cpu_touch   = cpu_w4016 || !cpu_n_r4016 || !cpu_n_r4017;

    // Right-shift from the MSB: new (de-inverted) pad bit enters at the top,
    // so after NUM_BITS reads the first bit read lands in bit 0.
    generate
        for (genvar gi = 0; gi < NUM_BITS - 1; gi++) begin : g_shift
            assign shift0_next[gi] = shift0_q[gi + 1];
            assign shift1_next[gi] = shift1_q[gi + 1];
        end
    endgenerate
    assign shift0_next[NUM_BITS-1] = ~pad_d0;
    assign shift1_next[NUM_BITS-1] = ~pad_d1;

    // State register.
    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the read sequence.
    always_comb begin
        state_d = state_q;
        if (abort_now) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_d = ST_STROBE_HI;
                    end
                end
                ST_STROBE_HI: begin
                    if (strobe_last) begin
                        state_d = ST_STROBE_LO;
                    end
                end
                ST_STROBE_LO: begin
                    state_d = ST_READ;
                end
                ST_READ: begin
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state_d = more_bits ? ST_READ : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the state, plus the pad ownership mux.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        strobe_int = (state_q == ST_STROBE_HI);
        n_in_int   = (state_q != ST_READ);
        if (busy) begin
            out0_drv  = strobe_int;
            n_in0_drv = n_in_int;
            n_in1_drv = n_in_int;
        end else begin
            out0_drv  = cpu_out0;
            n_in0_drv = cpu_n_r4016;
            n_in1_drv = cpu_n_r4017;
        end
    end

    // Next values for counters, shift registers, results and the collision flag.
    always_comb begin
        phase_cnt_d = '0;
        bit_cnt_d   = bit_cnt_q;
        shift0_d    = shift0_q;
        shift1_d    = shift1_q;
        res0_d      = res0_q;
        res1_d      = res1_q;
        collision_d = collision_q;

        if (busy && cpu_touch) begin
            collision_d = 1'b1;
        end

        if (abort_now) begin
            bit_cnt_d = '0;
            shift0_d  = '0;
            shift1_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        bit_cnt_d   = '0;
                        shift0_d    = '0;
                        shift1_d    = '0;
                        collision_d = 1'b0;
                    end
                end
                ST_STROBE_HI: begin
                    if (!strobe_last) begin
                        phase_cnt_d = phase_cnt_q + PW'(1);
                    end
                end
                ST_STROBE_LO: begin
                    phase_cnt_d = '0;
                end
                ST_READ: begin
                    shift0_d = shift0_next;
                    shift1_d = shift1_next;
                end
                ST_GAP: begin
                    if (gap_last) begin
                        bit_cnt_d = bit_cnt_inc;
                    end else begin
                        phase_cnt_d = phase_cnt_q + PW'(1);
                    end
                end
                ST_DONE: begin
                    res0_d = shift0_q;
                    res1_d = shift1_q;
                end
                default: begin
                    phase_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            phase_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift0_q    <= '0;
            shift1_q    <= '0;
            res0_q      <= '0;
            res1_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift0_q    <= shift0_d;
            shift1_q    <= shift1_d;
            res0_q      <= res0_d;
            res1_q      <= res1_d;
            collision_q <= collision_d;
        end
    end

    assign pad0_data = res0_q;
    assign pad1_data = res1_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_pad_autoread_ctrl.sv
// Directed bench for pad_autoread_ctrl: default instance plus a small
// NUM_BITS=4 / STROBE_CYCLES=1 / READ_GAP=2 instance.
module tb_pad_autoread_ctrl;

    logic ACLK1 = 1'b0;
    logic n_RES;

    // default-parameter instance
    logic start, abort, cpu_out0, cpu_n_r4016, cpu_n_r4017, cpu_w4016, pad_d0, pad_d1;
    logic out0_drv, n_in0_drv, n_in1_drv, busy, done, collision;
    logic [7:0] pad0_data, pad1_data;

    // small instance
    logic s_start, s_abort, s_cpu_out0, s_cpu_n_r4016, s_cpu_n_r4017, s_cpu_w4016, s_pad_d0, s_pad_d1;
    logic s_out0_drv, s_n_in0_drv, s_n_in1_drv, s_busy, s_done, s_collision;
    logic [3:0] s_pad0_data, s_pad1_data;

    int checks = 0;
    int errors = 0;

    int busy_n, strobe_n, low_n, fall_n, first_low, last_low, done_n, done_c, pair_bad, coll_c1, pad_bad;

    always #5 ACLK1 = ~ACLK1;

    pad_autoread_ctrl u_dut (
        .ACLK1(ACLK1), .n_RES(n_RES), .start(start), .abort(abort),
        .cpu_out0(cpu_out0), .cpu_n_r4016(cpu_n_r4016), .cpu_n_r4017(cpu_n_r4017),
        .cpu_w4016(cpu_w4016), .pad_d0(pad_d0), .pad_d1(pad_d1),
        .out0_drv(out0_drv), .n_in0_drv(n_in0_drv), .n_in1_drv(n_in1_drv),
        .busy(busy), .done(done), .pad0_data(pad0_data), .pad1_data(pad1_data),
        .collision(collision)
    );

    pad_autoread_ctrl #(.NUM_BITS(4), .STROBE_CYCLES(1), .READ_GAP(2)) u_small (
        .ACLK1(ACLK1), .n_RES(n_RES), .start(s_start), .abort(s_abort),
        .cpu_out0(s_cpu_out0), .cpu_n_r4016(s_cpu_n_r4016), .cpu_n_r4017(s_cpu_n_r4017),
        .cpu_w4016(s_cpu_w4016), .pad_d0(s_pad_d0), .pad_d1(s_pad_d1),
        .out0_drv(s_out0_drv), .n_in0_drv(s_n_in0_drv), .n_in1_drv(s_n_in1_drv),
        .busy(s_busy), .done(s_done), .pad0_data(s_pad0_data), .pad1_data(s_pad1_data),
        .collision(s_collision)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one auto-read and observe 26 cycles at mid-cycle (negedge).
    // The pads answer each /IN low pulse with the next bit of v0/v1 (inverted).
    task automatic run_read(input int which, input logic [15:0] v0, input logic [15:0] v1,
                            input int coll_at, input int abort_at, input int restart_at);
        int reads;
        logic prev_n, b, o, n0, n1, d;
        reads = 0; prev_n = 1'b1;
        busy_n = 0; strobe_n = 0; low_n = 0; fall_n = 0; first_low = -1; last_low = -1;
        done_n = 0; done_c = -1; pair_bad = 0; coll_c1 = -1; pad_bad = 0;
        @(negedge ACLK1);
        if (which == 1) s_start = 1'b1; else start = 1'b1;
        @(negedge ACLK1);
        for (int c = 1; c <= 26; c++) begin
            if (c > 1) @(negedge ACLK1);
            start = 1'b0; s_start = 1'b0; abort = 1'b0; s_abort = 1'b0;
            cpu_n_r4017 = 1'b1; cpu_w4016 = 1'b0;
            b  = (which == 1) ? s_busy      : busy;
            o  = (which == 1) ? s_out0_drv  : out0_drv;
            n0 = (which == 1) ? s_n_in0_drv : n_in0_drv;
            n1 = (which == 1) ? s_n_in1_drv : n_in1_drv;
            d  = (which == 1) ? s_done      : done;
            if (c == 1) coll_c1 = (which == 1) ? int'(s_collision) : int'(collision);
            if (b) busy_n++;
            if (b && o) strobe_n++;
            if (n0 !== n1) pair_bad++;
            if (!n0) begin
                low_n++;
                if (prev_n) fall_n++;
                if (first_low < 0) first_low = c;
                last_low = c;
                if (which == 1) begin
                    s_pad_d0 = ~v0[reads]; s_pad_d1 = ~v1[reads];
                end else begin
                    pad_d0 = ~v0[reads]; pad_d1 = ~v1[reads];
                end
                reads++;
            end
            prev_n = n0;
            if (d) begin
                done_n++;
                done_c = c;
            end
            if (c == abort_at) begin
                if (which == 1) s_abort = 1'b1; else abort = 1'b1;
            end
            if (c == restart_at) begin
                if (which == 1) s_start = 1'b1; else start = 1'b1;
            end
            if (c == coll_at) begin
                cpu_n_r4017 = 1'b0; cpu_w4016 = 1'b1;
                #1;
                if (n_in1_drv !== 1'b1 || out0_drv !== 1'b0) pad_bad++;
            end
        end
    endtask

    initial begin
        n_RES = 1'b0;
        start = 0; abort = 0; cpu_out0 = 0; cpu_n_r4016 = 1; cpu_n_r4017 = 1; cpu_w4016 = 0;
        pad_d0 = 1; pad_d1 = 1;
        s_start = 0; s_abort = 0; s_cpu_out0 = 0; s_cpu_n_r4016 = 1; s_cpu_n_r4017 = 1;
        s_cpu_w4016 = 0; s_pad_d0 = 1; s_pad_d1 = 1;

        // Reset held mid-cycle, pass-through of CPU path
        @(negedge ACLK1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_pad0", pad0_data, 0);
        chk("rst_pad1", pad1_data, 0);
        cpu_out0 = 1; cpu_n_r4016 = 0;
        #1;
        chk("rst_pass_out0", out0_drv, 1);
        chk("rst_pass_in0", n_in0_drv, 0);
        chk("rst_pass_in1", n_in1_drv, 1);
        cpu_n_r4016 = 1;
        @(negedge ACLK1);
        n_RES = 1'b1;

        // Full default read: 0xA5 / 0x3C
        run_read(0, 16'h00A5, 16'h003C, -1, -1, -1);
        $display("read1: busy=%0d strobe=%0d lows=%0d first=%0d last=%0d done@%0d pad0=%h pad1=%h",
                 busy_n, strobe_n, low_n, first_low, last_low, done_c, pad0_data, pad1_data);
        chk("r1_busy_len", busy_n, 20);
        chk("r1_strobe_len", strobe_n, 2);
        chk("r1_in_low", low_n, 8);
        chk("r1_in_falls", fall_n, 8);
        chk("r1_first_low", first_low, 4);
        chk("r1_last_low", last_low, 18);
        chk("r1_done_cnt", done_n, 1);
        chk("r1_done_cycle", done_c, 20);
        chk("r1_in_pair", pair_bad, 0);
        chk("r1_pad0", pad0_data, 8'hA5);
        chk("r1_pad1", pad1_data, 8'h3C);
        chk("r1_collision", collision, 0);
        chk("r1_out0_pass", out0_drv, 1);

        // Collision during a read: 0x5A / 0xC3
        run_read(0, 16'h005A, 16'h00C3, 5, -1, -1);
        $display("read2: busy=%0d done=%0d pad_bad=%0d coll=%0b pad0=%h pad1=%h",
                 busy_n, done_n, pad_bad, collision, pad0_data, pad1_data);
        chk("r2_pads_held", pad_bad, 0);
        chk("r2_collision", collision, 1);
        chk("r2_busy_len", busy_n, 20);
        chk("r2_done_cnt", done_n, 1);
        chk("r2_pad0", pad0_data, 8'h5A);
        chk("r2_pad1", pad1_data, 8'hC3);

        // Abort in the GAP after the 3rd READ
        run_read(0, 16'h00FF, 16'h0000, -1, 9, -1);
        $display("read3 abort: busy=%0d done=%0d lows=%0d coll_c1=%0d pad0=%h pad1=%h",
                 busy_n, done_n, low_n, coll_c1, pad0_data, pad1_data);
        chk("r3_coll_cleared", coll_c1, 0);
        chk("r3_busy_len", busy_n, 9);
        chk("r3_done_cnt", done_n, 0);
        chk("r3_in_low", low_n, 3);
        chk("r3_pad0_kept", pad0_data, 8'h5A);
        chk("r3_pad1_kept", pad1_data, 8'hC3);
        chk("r3_out0_pass", out0_drv, 1);

        // start and abort together in IDLE
        @(negedge ACLK1);
        start = 1; abort = 1;
        @(negedge ACLK1);
        start = 0; abort = 0;
        $display("start+abort: busy=%0b", busy);
        chk("sa_busy0", busy, 0);
        @(negedge ACLK1);
        chk("sa_busy1", busy, 0);

        // Start while busy is ignored: 0x81 / 0x7E
        run_read(0, 16'h0081, 16'h007E, -1, -1, 10);
        $display("read4 restart: busy=%0d done=%0d done@%0d pad0=%h pad1=%h",
                 busy_n, done_n, done_c, pad0_data, pad1_data);
        chk("r4_busy_len", busy_n, 20);
        chk("r4_done_cnt", done_n, 1);
        chk("r4_done_cycle", done_c, 20);
        chk("r4_pad0", pad0_data, 8'h81);
        chk("r4_pad1", pad1_data, 8'h7E);

        // Small instance: NUM_BITS=4, STROBE_CYCLES=1, READ_GAP=2, data 0xA / 0x3
        run_read(1, 16'h000A, 16'h0003, -1, -1, -1);
        $display("small: busy=%0d strobe=%0d lows=%0d first=%0d last=%0d done@%0d pad0=%h pad1=%h",
                 busy_n, strobe_n, low_n, first_low, last_low, done_c, s_pad0_data, s_pad1_data);
        chk("s_busy_len", busy_n, 15);
        chk("s_strobe_len", strobe_n, 1);
        chk("s_in_low", low_n, 4);
        chk("s_in_falls", fall_n, 4);
        chk("s_first_low", first_low, 3);
        chk("s_last_low", last_low, 12);
        chk("s_done_cycle", done_c, 15);
        chk("s_pad0", s_pad0_data, 4'hA);
        chk("s_pad1", s_pad1_data, 4'h3);

        // Reset mid-operation: pads revert immediately
        @(negedge ACLK1);
        start = 1;
        @(negedge ACLK1);
        start = 0;
        repeat (3) @(negedge ACLK1);
        chk("rm_busy_before", busy, 1);
        #2;
        n_RES = 1'b0;
        #1;
        $display("reset mid-op: busy=%0b out0=%0b pad0=%h", busy, out0_drv, pad0_data);
        chk("rm_busy", busy, 0);
        chk("rm_out0_pass", out0_drv, 1);
        chk("rm_in0_pass", n_in0_drv, 1);
        chk("rm_pad0", pad0_data, 0);
        @(negedge ACLK1);
        n_RES = 1'b1;
        @(negedge ACLK1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
